// File: rtl/spi_readback_4mb_pkg.sv
// Shared constants for the SPI read-back path: address map and FSM encoding.
package spi_readback_4mb_pkg;

    localparam logic [15:0] ADDR_FPGA_VER          = 16'h0000;
    localparam logic [15:0] ADDR_FPGA_REV_DATE     = 16'h0001;
    localparam logic [15:0] ADDR_FPGA_DIP_SW       = 16'h0002;
    localparam logic [15:0] ADDR_FPGA_BUTTONS      = 16'h0003;
    localparam logic [15:0] ADDR_FPGA_BUTTONS_LED  = 16'h0004;
    localparam logic [15:0] ADDR_FPGA_DRAPE_SWITCH = 16'h0005;
    localparam logic [15:0] ADDR_FPGA_SPARE0_IO    = 16'h0006;
    localparam logic [15:0] ADDR_FPGA_SPARE1_IO    = 16'h0007;
    localparam logic [15:0] ADDR_ADC_ALERTS        = 16'h0008;
    localparam logic [15:0] ADDR_FAULT_FLAGS       = 16'h0009;
    localparam logic [15:0] ADDR_ABS_ENC_CTRL      = 16'h000A;
    localparam logic [15:0] ADDR_FAULT_LATCH       = 16'h000B;
    localparam logic [15:0] ADDR_RD_STATUS         = 16'h000C;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_PRESENT = 2'd2
    } rd_state_e;

endpackage

// File: rtl/spi_readback_4mb_if.sv
// Read request / response handshake between the SPI slave core and read-back.
interface spi_readback_4mb_if;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic        miso_ack;
    logic [31:0] data_miso;
    logic        data_miso_rdy;
    logic        rd_busy;

    modport master (
        output rd_req, rd_addr, miso_ack,
        input  data_miso, data_miso_rdy, rd_busy
    );

    modport slave (
        input  rd_req, rd_addr, miso_ack,
        output data_miso, data_miso_rdy, rd_busy
    );
endinterface

// File: rtl/sticky_latch_4mb.sv
// OR-accumulating sticky bits; a clear loses to a set arriving the same cycle.
module sticky_latch_4mb #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_set,
    input  logic         i_clr,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_q <= '0;
        else if (i_clr) r_q <= i_set;
        else r_q <= r_q | i_set;
    end

    assign o_q = r_q;
endmodule

// File: rtl/spi_readback_4mb.sv
// SPI register read-back: address mux, present/ack FSM, clear-on-read status.
module spi_readback_4mb
    import spi_readback_4mb_pkg::*;
#(
    parameter int          TIMEOUT_CYC  = 1000,
    parameter logic [31:0] UNMAPPED_VAL = 32'hBADC_0DE0,
    parameter int          OVR_W        = 8
) (
    input  logic        clk_100m,
    input  logic        rst_n_syn,
    spi_readback_4mb_if.slave bus,
    input  logic [31:0] ver_reg,
    input  logic [31:0] rev_data_reg,
    input  logic [31:0] dip_sw_reg,
    input  logic [31:0] buttons_reg,
    input  logic [31:0] buttons_led_reg,
    input  logic [31:0] drape_sensor_reg,
    input  logic [31:0] spare0_io_reg,
    input  logic [31:0] spare1_io_reg,
    input  logic [31:0] ADC_Alerts_reg,
    input  logic [31:0] Fault_Flages_reg,
    input  logic [31:0] ABS_ENC_CTRL_REG
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    rd_state_e      r_state, w_next;
    logic [15:0]    r_addr;
    logic [31:0]    r_data;
    logic           r_rdy;
    logic [TW-1:0]  r_tmr;
    logic [OVR_W-1:0] r_ovr;

    logic           w_accept, w_load, w_ack, w_tout, w_ovr;
    logic           w_unmapped, w_clr_latch, w_clr_stat;
    logic [31:0]    w_mux, w_status;
    logic [17:0]    w_latch;
    logic [1:0]     w_stat;

    always_ff @(posedge clk_100m) begin
        if (!rst_n_syn) r_state <= ST_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_load   = 1'b0;
        w_ack    = 1'b0;
        w_tout   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.rd_req) begin
                    w_accept = 1'b1;
                    w_next   = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                w_load = 1'b1;
                w_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (bus.miso_ack) begin
                    w_ack  = 1'b1;
                    w_next = ST_IDLE;
                end else if (r_tmr == TW'(TIMEOUT_CYC - 1)) begin
                    w_tout = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_status = 32'({r_ovr, 6'b0, w_stat});

    always_comb begin
        w_unmapped = 1'b0;
        case (r_addr)
            ADDR_FPGA_VER:          w_mux = ver_reg;
            ADDR_FPGA_REV_DATE:     w_mux = rev_data_reg;
            ADDR_FPGA_DIP_SW:       w_mux = dip_sw_reg;
            ADDR_FPGA_BUTTONS:      w_mux = buttons_reg;
            ADDR_FPGA_BUTTONS_LED:  w_mux = buttons_led_reg;
            ADDR_FPGA_DRAPE_SWITCH: w_mux = drape_sensor_reg;
            ADDR_FPGA_SPARE0_IO:    w_mux = spare0_io_reg;
            ADDR_FPGA_SPARE1_IO:    w_mux = spare1_io_reg;
            ADDR_ADC_ALERTS:        w_mux = ADC_Alerts_reg;
            ADDR_FAULT_FLAGS:       w_mux = Fault_Flages_reg;
            ADDR_ABS_ENC_CTRL:      w_mux = ABS_ENC_CTRL_REG;
            ADDR_FAULT_LATCH:       w_mux = {14'b0, w_latch};
            ADDR_RD_STATUS:         w_mux = w_status;
            default: begin
                w_mux      = UNMAPPED_VAL;
                w_unmapped = 1'b1;
            end
        endcase
    end

    assign w_ovr       = bus.rd_req && (r_state != ST_IDLE);
    assign w_clr_latch = w_ack && (r_addr == ADDR_FAULT_LATCH);
    assign w_clr_stat  = w_ack && (r_addr == ADDR_RD_STATUS);

    always_ff @(posedge clk_100m) begin
        if (!rst_n_syn) begin
            r_addr <= '0;
            r_data <= '0;
            r_rdy  <= 1'b0;
            r_tmr  <= '0;
        end else begin
            if (w_accept) r_addr <= bus.rd_addr;
            if (w_load) begin
                r_data <= w_mux;
                r_rdy  <= 1'b1;
                r_tmr  <= '0;
            end else if (w_ack || w_tout) begin
                r_rdy  <= 1'b0;
            end else if (r_state == ST_PRESENT) begin
                r_tmr  <= r_tmr + 1'b1;
            end
        end
    end

    // Overrun in the clearing cycle restarts the count at one.
    always_ff @(posedge clk_100m) begin
        if (!rst_n_syn) r_ovr <= '0;
        else if (w_clr_stat) r_ovr <= OVR_W'(w_ovr);
        else if (w_ovr && (r_ovr != '1)) r_ovr <= r_ovr + 1'b1;
    end

    sticky_latch_4mb #(.W(18)) u_fault_latch (
        .i_clk   (clk_100m),
        .i_rst_n (rst_n_syn),
        .i_set   ({ADC_Alerts_reg[1:0], Fault_Flages_reg[15:0]}),
        .i_clr   (w_clr_latch),
        .o_q     (w_latch)
    );

    sticky_latch_4mb #(.W(2)) u_status (
        .i_clk   (clk_100m),
        .i_rst_n (rst_n_syn),
        .i_set   ({w_load && w_unmapped, w_tout}),
        .i_clr   (w_clr_stat),
        .o_q     (w_stat)
    );

    assign bus.data_miso     = r_data;
    assign bus.data_miso_rdy = r_rdy;
    assign bus.rd_busy       = (r_state != ST_IDLE);
endmodule

// File: doc/spi_readback_4mb.md
Name: spi_readback_4mb

Overview:
- Read-direction counterpart to the register block's SPI write path.
- Accepts a read request (address) from the SPI slave core and selects the addressed 32-bit register.
- Presents the result on data_miso with a valid/ack handshake.
- Keeps clear-on-read sticky latches for fault/alert events and a read-path status register.

Parameters:
- TIMEOUT_CYC, 1000: cycles data_miso_rdy may stay high without miso_ack before the read is abandoned.
- UNMAPPED_VAL, 32'hBADC_0DE0: data returned for an unmapped address.
- OVR_W, 8: width of the saturating overrun counter.

Ports:
- clk_100m  in  1  system clock, 100 MHz
- rst_n_syn  in  1  reset, synchronous, active-low
- rd_req  in  1  one-cycle read strobe from SPI slave core
- rd_addr  in  16  read address, valid with rd_req
- miso_ack  in  1  SPI core has loaded data_miso into its shifter
- ver_reg, rev_data_reg, dip_sw_reg, buttons_reg, buttons_led_reg, drape_sensor_reg, spare0_io_reg, spare1_io_reg, ADC_Alerts_reg, Fault_Flages_reg, ABS_ENC_CTRL_REG  in  32 each  live register values
- data_miso  out  32  read data
- data_miso_rdy  out  1  data_miso valid, held until ack or timeout
- rd_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n_syn low at a clk_100m edge) clears all of the following to 0 and forces IDLE:
  - data_miso, data_miso_rdy, rd_busy
  - fault_latch[15:0], alert_latch[1:0]
  - timeout_stk, addr_err_stk, overrun_cnt
- Reset mid-read aborts the read with no ack side effects.

FSM states: IDLE, LOOKUP, PRESENT.
- IDLE: rd_req at edge N latches rd_addr and moves to LOOKUP.
- LOOKUP: at edge N+1, data_miso is registered from the address mux; moves to PRESENT.
  - data_miso_rdy = 1 from cycle N+2, giving a latency of 2 clocks.
- PRESENT, miso_ack = 1: drop rdy, apply clear-on-read for the latched address, return to IDLE. The next rd_req is accepted one cycle later.
- PRESENT, no ack: a timer counts cycles in PRESENT. When it reaches TIMEOUT_CYC:
  - drop rdy, set timeout_stk, go to IDLE
  - no clear-on-read is applied
- rd_req while not in IDLE: ignored; overrun_cnt increments and saturates at all-ones.
- data_miso holds its last value after rdy drops.

Address map (constants in parameters_4mb.v):
- Existing addresses:
  - ADDR_FPGA_VER, ADDR_FPGA_REV_DATE, ADDR_FPGA_DIP_SW
  - ADDR_FPGA_BUTTONS, ADDR_FPGA_BUTTONS_LED, ADDR_FPGA_DRAPE_SWITCH
  - ADDR_FPGA_SPARE0_IO, ADDR_FPGA_SPARE1_IO
  - ADDR_ADC_ALERTS, ADDR_FAULT_FLAGS, ADDR_ABS_ENC_CTRL
- New addresses:
  - ADDR_FAULT_LATCH: returns {14'b0, alert_latch, fault_latch}
  - ADDR_RD_STATUS: returns {16'b0, overrun_cnt, 6'b0, addr_err_stk, timeout_stk}
- Any other address returns UNMAPPED_VAL and sets addr_err_stk in LOOKUP.

Sticky latches:
- Every cycle: fault_latch |= Fault_Flages_reg[15:0] and alert_latch |= ADC_Alerts_reg[1:0].
- An acked read of ADDR_FAULT_LATCH clears both latches.
- An acked read of ADDR_RD_STATUS clears timeout_stk, addr_err_stk and overrun_cnt.
- Set beats clear: a source bit high in the ack cycle leaves its latch bit set. An overrun in the ack cycle leaves overrun_cnt = 1.
- Captured value: what data_miso returns is the LOOKUP-cycle snapshot. Events arriving after LOOKUP survive the clear only if still high during the ack cycle; otherwise they are lost. This is accepted.

Decomposition:
- parameters_4mb.v gains:
  - ADDR_ADC_ALERTS, ADDR_FAULT_FLAGS (if not present)
  - ADDR_FAULT_LATCH, ADDR_RD_STATUS
  - localparams for the FSM state encodings (2-bit)
- One natural sub-module: sticky_latch_4mb, a parameterised-width OR-accumulate with set-priority clear. It is instantiated for fault_latch/alert_latch and for the two status bits.
- Address mux and FSM remain in the top of this block.

Test Plan:
- Reset, then rd_req with rd_addr=ADDR_FPGA_VER, ver_reg=32'h0000_0103 -> data_miso_rdy rises exactly 2 clocks later with data_miso=32'h0000_0103; miso_ack drops rdy next cycle; rd_busy low.
- Pulse Fault_Flages_reg=16'h0005 for 1 cycle, then read ADDR_FAULT_LATCH with ack -> 32'h0000_0005. Second read -> 32'h0000_0000.
- Hold Fault_Flages_reg[3]=1 through an acked ADDR_FAULT_LATCH read -> bit 3 still set on the next read (set beats clear).
- Read, with no ack for 1000 cycles -> rdy drops at cycle 1000 of PRESENT. Next ADDR_RD_STATUS read returns bit0=1; a following status read returns 0.
- rd_req pulsed 3 times during PRESENT, then rd_addr=16'hFFFF read -> 32'hBADC_0DE0. Status read -> overrun_cnt=3 at bits [15:8], addr_err_stk=1 at bit 1.
- rst_n_syn asserted during PRESENT of an ADDR_FAULT_LATCH read -> all outputs 0 next cycle, FSM in IDLE, latches cleared by reset only.
